// File: rtl/imem_dmem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and data access,
// with data priority, a bounded fetch-starvation streak and branch-kill suppression of fetch acks.
module imem_dmem_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_f,
  output logic                stall_m
);

  localparam int unsigned BE_W     = DATA_W / 8;
  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    DRAIN_I = 2'd3
  } arbState_e;

  arbState_e           state;
  logic [STREAK_W-1:0] streak;
  logic                grantD;
  logic                grantI;

  // Data wins unless a waiting fetch has already sat through a full data streak.
  always_comb begin
    grantD = 1'b0;
    grantI = 1'b0;
    if (state == IDLE) begin
      grantD = d_req & (~if_req | (streak != STREAK_MAX));
      grantI = if_req & ~grantD;
    end
  end

  // A kill landing in the completion cycle still swallows the fetch ack.
  assign d_ack    = (state == BUSY_D) & mem_ack;
  assign if_ack   = (state == BUSY_I) & mem_ack & ~if_kill;
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;
  assign stall_f  = rst_n & if_req & ~if_ack;
  assign stall_m  = rst_n & d_req & ~d_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!if_req || grantI) begin
            streak <= '0;
          end else if (grantD && (streak != STREAK_MAX)) begin
            streak <= streak + STREAK_W'(1);
          end
          if (grantD) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= BUSY_D;
          end else if (grantI) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= {BE_W{1'b1}};
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= if_kill ? DRAIN_I : BUSY_I;
          end
        end
        BUSY_I: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (if_kill) begin
            state <= DRAIN_I;
          end
        end
        BUSY_D, DRAIN_I: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
